// File: rtl/gbc_bus_arbiter.sv
// Two-initiator pipelined Wishbone arbiter for the GBC memory bus (CPU = initiator 0,
// OAM/HDMA DMA = initiator 1) with outstanding-strobe limiting and ACK timeout abort.
module gbc_bus_arbiter #(
   parameter int unsigned AddressWidth   = 16,
   parameter int unsigned DataWidth      = 8,
   parameter string       Policy         = "Fixed",
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned TimeoutCycles  = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i0_cyc,
   input  logic                    i0_stb,
   input  logic                    i0_we,
   input  logic [AddressWidth-1:0] i0_adr,
   input  logic [DataWidth-1:0]    i0_dat_w,
   output logic [DataWidth-1:0]    i0_dat_r,
   output logic                    i0_ack,
   output logic                    i0_stall,
   output logic                    i0_err,
   input  logic                    i1_cyc,
   input  logic                    i1_stb,
   input  logic                    i1_we,
   input  logic [AddressWidth-1:0] i1_adr,
   input  logic [DataWidth-1:0]    i1_dat_w,
   output logic [DataWidth-1:0]    i1_dat_r,
   output logic                    i1_ack,
   output logic                    i1_stall,
   output logic                    i1_err,
   output logic                    t_cyc,
   output logic                    t_stb,
   output logic                    t_we,
   output logic [AddressWidth-1:0] t_adr,
   output logic [DataWidth-1:0]    t_dat_w,
   input  logic [DataWidth-1:0]    t_dat_r,
   input  logic                    t_ack,
   input  logic                    t_stall,
   output logic [1:0]              grant
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      ABORT = 2'd3
   } state_t;

   localparam logic [3:0]  MaxOut     = 4'(MaxOutstanding);
   localparam logic [15:0] TimeLast   = 16'(TimeoutCycles - 1);
   localparam bit          RoundRobin = (Policy == "RoundRobin");

   state_t                  state_r;
   logic [1:0]              grant_r;
   logic [3:0]              outstanding_r;
   logic [15:0]             timer_r;
   logic                    pref_r;

   logic                    own_s;
   logic                    own_cyc_s;
   logic                    own_stb_s;
   logic                    own_we_s;
   logic [AddressWidth-1:0] own_adr_s;
   logic [DataWidth-1:0]    own_dat_w_s;
   logic                    full_s;
   logic                    pend_s;
   logic                    accept_s;
   logic                    fwd_ack_s;
   logic                    tmo_s;

   assign grant    = grant_r;
   assign i0_dat_r = t_dat_r;
   assign i1_dat_r = t_dat_r;

   // Select the current owner's request signals and derive bus-cycle status.
   always_comb begin
      own_s       = (state_r == OWN0) || (state_r == OWN1);
      own_cyc_s   = grant_r[1] ? i1_cyc   : i0_cyc;
      own_stb_s   = grant_r[1] ? i1_stb   : i0_stb;
      own_we_s    = grant_r[1] ? i1_we    : i0_we;
      own_adr_s   = grant_r[1] ? i1_adr   : i0_adr;
      own_dat_w_s = grant_r[1] ? i1_dat_w : i0_dat_w;
      full_s      = (outstanding_r == MaxOut);
      pend_s      = (outstanding_r != 4'd0);
      fwd_ack_s   = own_s & t_ack & pend_s;
      // A same-cycle ACK beats the timeout.
      tmo_s       = own_s & own_cyc_s & pend_s & ~t_ack & (timer_r == TimeLast);
   end

   // Drive target and initiator handshake outputs from the owner mux.
   always_comb begin
      t_cyc   = 1'b0;
      t_stb   = 1'b0;
      t_we    = 1'b0;
      t_adr   = {AddressWidth{1'b0}};
      t_dat_w = {DataWidth{1'b0}};
      if (own_s) begin
         t_cyc   = own_cyc_s;
         t_stb   = own_stb_s & ~full_s;
         t_we    = own_we_s;
         t_adr   = own_adr_s;
         t_dat_w = own_dat_w_s;
      end else begin
         t_cyc   = 1'b0;
      end
      accept_s = t_stb & ~t_stall;
      i0_ack   = (state_r == OWN0) & fwd_ack_s;
      i1_ack   = (state_r == OWN1) & fwd_ack_s;
      i0_err   = (state_r == OWN0) & tmo_s;
      i1_err   = (state_r == OWN1) & tmo_s;
      i0_stall = (state_r == OWN0) ? (t_stall | full_s) : 1'b1;
      i1_stall = (state_r == OWN1) ? (t_stall | full_s) : 1'b1;
   end

   // Ownership FSM with outstanding-strobe counter and ACK timeout timer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= IDLE;
         grant_r       <= 2'b00;
         outstanding_r <= 4'd0;
         timer_r       <= 16'd0;
         pref_r        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               outstanding_r <= 4'd0;
               timer_r       <= 16'd0;
               if (i0_cyc && i1_cyc) begin
                  if (RoundRobin && pref_r) begin
                     state_r <= OWN1;
                     grant_r <= 2'b10;
                     pref_r  <= 1'b0;
                  end else begin
                     state_r <= OWN0;
                     grant_r <= 2'b01;
                     pref_r  <= 1'b1;
                  end
               end else if (i0_cyc) begin
                  state_r <= OWN0;
                  grant_r <= 2'b01;
               end else if (i1_cyc) begin
                  state_r <= OWN1;
                  grant_r <= 2'b10;
               end else begin
                  grant_r <= 2'b00;
               end
            end
            OWN0, OWN1: begin
               if (!own_cyc_s) begin
                  // Owner abandons the cycle; any late ACKs are dropped in IDLE.
                  state_r       <= IDLE;
                  grant_r       <= 2'b00;
                  outstanding_r <= 4'd0;
                  timer_r       <= 16'd0;
               end else if (tmo_s) begin
                  state_r       <= ABORT;
                  outstanding_r <= 4'd0;
                  timer_r       <= 16'd0;
               end else begin
                  outstanding_r <= outstanding_r + {3'b000, accept_s} - {3'b000, fwd_ack_s};
                  if (fwd_ack_s || !pend_s) begin
                     timer_r <= 16'd0;
                  end else begin
                     timer_r <= timer_r + 16'd1;
                  end
               end
            end
            ABORT: begin
               outstanding_r <= 4'd0;
               timer_r       <= 16'd0;
               if (!own_cyc_s) begin
                  state_r <= IDLE;
                  grant_r <= 2'b00;
               end else begin
                  state_r <= ABORT;
               end
            end
            default: begin
               state_r       <= IDLE;
               grant_r       <= 2'b00;
               outstanding_r <= 4'd0;
               timer_r       <= 16'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gbc_bus_arbiter.sv
// Directed bench for gbc_bus_arbiter: a RoundRobin and a Fixed instance share one stimulus.
module tb_gbc_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        c0, s0, w0, c1, s1, w1, tack, tstall;
   logic [15:0] a0, a1;
   logic [7:0]  d0, d1, tdr;

   logic [7:0]  r_dr0, r_dr1, f_dr0, f_dr1, r_tdw, f_tdw;
   logic        r_ack0, r_ack1, r_stall0, r_stall1, r_err0, r_err1;
   logic        f_ack0, f_ack1, f_stall0, f_stall1, f_err0, f_err1;
   logic        r_tcyc, r_tstb, r_twe, f_tcyc, f_tstb, f_twe;
   logic [15:0] r_tadr, f_tadr;
   logic [1:0]  r_grant, f_grant;

   int n_cmp = 0;
   int n_bad = 0;
   int acc;
   int e_at;

   always #5 clk = ~clk;

   gbc_bus_arbiter #(.AddressWidth(16), .DataWidth(8), .Policy("RoundRobin"),
                     .MaxOutstanding(4), .TimeoutCycles(16)) dut_rr (
      .clk(clk), .rst(rst),
      .i0_cyc(c0), .i0_stb(s0), .i0_we(w0), .i0_adr(a0), .i0_dat_w(d0),
      .i0_dat_r(r_dr0), .i0_ack(r_ack0), .i0_stall(r_stall0), .i0_err(r_err0),
      .i1_cyc(c1), .i1_stb(s1), .i1_we(w1), .i1_adr(a1), .i1_dat_w(d1),
      .i1_dat_r(r_dr1), .i1_ack(r_ack1), .i1_stall(r_stall1), .i1_err(r_err1),
      .t_cyc(r_tcyc), .t_stb(r_tstb), .t_we(r_twe), .t_adr(r_tadr), .t_dat_w(r_tdw),
      .t_dat_r(tdr), .t_ack(tack), .t_stall(tstall), .grant(r_grant)
   );

   gbc_bus_arbiter #(.AddressWidth(16), .DataWidth(8), .Policy("Fixed"),
                     .MaxOutstanding(4), .TimeoutCycles(16)) dut_fx (
      .clk(clk), .rst(rst),
      .i0_cyc(c0), .i0_stb(s0), .i0_we(w0), .i0_adr(a0), .i0_dat_w(d0),
      .i0_dat_r(f_dr0), .i0_ack(f_ack0), .i0_stall(f_stall0), .i0_err(f_err0),
      .i1_cyc(c1), .i1_stb(s1), .i1_we(w1), .i1_adr(a1), .i1_dat_w(d1),
      .i1_dat_r(f_dr1), .i1_ack(f_ack1), .i1_stall(f_stall1), .i1_err(f_err1),
      .t_cyc(f_tcyc), .t_stb(f_tstb), .t_we(f_twe), .t_adr(f_tadr), .t_dat_w(f_tdw),
      .t_dat_r(tdr), .t_ack(tack), .t_stall(tstall), .grant(f_grant)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start a new cycle: inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      c0 = 1'b0; s0 = 1'b0; w0 = 1'b0; a0 = 16'h0000; d0 = 8'h00;
      c1 = 1'b0; s1 = 1'b0; w1 = 1'b0; a1 = 16'h0000; d1 = 8'h00;
      tack = 1'b0; tstall = 1'b0; tdr = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      #3;
      chk("rst_grant", 32'(r_grant), 32'd0);
      chk("rst_tcyc", 32'(r_tcyc), 32'd0);
      chk("rst_tstb", 32'(r_tstb), 32'd0);
      chk("rst_stall0", 32'(r_stall0), 32'd1);
      chk("rst_stall1", 32'(r_stall1), 32'd1);
      chk("rst_ack0", 32'(r_ack0), 32'd0);
      chk("rst_err0", 32'(r_err0), 32'd0);
      chk("rst_fx_grant", 32'(f_grant), 32'd0);
      step(); rst = 1'b1;

      // Single read by I0
      step(); c0 = 1'b1; s0 = 1'b1; a0 = 16'hC000; d0 = 8'h33; #2;
      chk("t1_idle_tcyc", 32'(r_tcyc), 32'd0);
      step(); #2;
      chk("t1_tcyc", 32'(r_tcyc), 32'd1);
      chk("t1_grant", 32'(r_grant), 32'd1);
      chk("t1_adr", 32'(r_tadr), 32'hC000);
      chk("t1_fx_datw", 32'(f_tdw), 32'h33);
      chk("t1_fx_we", 32'(f_twe), 32'd0);
      chk("t1_stall0", 32'(r_stall0), 32'd0);
      chk("t1_stall1", 32'(r_stall1), 32'd1);
      step(); s0 = 1'b0; tack = 1'b1; tdr = 8'h5A; #2;
      chk("t1_ack0", 32'(r_ack0), 32'd1);
      chk("t1_dat0", 32'(r_dr0), 32'h5A);
      chk("t1_fx_dat1", 32'(f_dr1), 32'h5A);
      chk("t1_ack1", 32'(r_ack1), 32'd0);
      chk("t1_stall1_b", 32'(r_stall1), 32'd1);
      step(); tack = 1'b0; c0 = 1'b0; #2;
      chk("t1_hold_grant", 32'(r_grant), 32'd1);
      step(); #2;
      chk("t1_end_grant", 32'(r_grant), 32'd0);

      // Contention: RoundRobin alternates, Fixed always picks I0
      for (int r = 0; r < 4; r++) begin
         step(); c0 = 1'b1; c1 = 1'b1; s0 = 1'b0; s1 = 1'b0; tack = 1'b0; #2;
         chk("t2_gap_rr", 32'(r_grant), 32'd0);
         chk("t2_gap_fx", 32'(f_grant), 32'd0);
         step(); s0 = 1'b1; s1 = 1'b1; #2;
         chk("t2_grant_rr", 32'(r_grant), (r % 2 == 0) ? 32'd1 : 32'd2);
         chk("t2_grant_fx", 32'(f_grant), 32'd1);
         step(); s0 = 1'b0; s1 = 1'b0; tack = 1'b1; c0 = 1'b0; c1 = 1'b0; #2;
         chk("t2_ack_rr", (r % 2 == 0) ? 32'(r_ack0) : 32'(r_ack1), 32'd1);
         chk("t2_ack_fx", 32'(f_ack0), 32'd1);
      end

      // Outstanding limit with I1
      step(); tack = 1'b0; c1 = 1'b1; #2;
      chk("t3_idle", 32'(r_grant), 32'd0);
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         step(); s1 = 1'b1; #2;
         if (r_tstb && !tstall) acc++;
      end
      chk("t3_accepts", 32'(acc), 32'd4);
      chk("t3_full_stall", 32'(r_stall1), 32'd1);
      step(); tack = 1'b1; #2;
      chk("t3_ack1", 32'(r_ack1), 32'd1);
      acc = 0;
      if (r_tstb) acc++;
      for (int k = 0; k < 3; k++) begin
         step(); tack = 1'b0; #2;
         if (r_tstb && !tstall) acc++;
      end
      chk("t3_one_more", 32'(acc), 32'd1);
      step(); s1 = 1'b0; c1 = 1'b0; #2;

      // ACK in the timeout cycle wins
      step(); c0 = 1'b1; #2;
      chk("t4_idle", 32'(r_grant), 32'd0);
      step(); s0 = 1'b1; #2;
      acc = 0;
      for (int k = 1; k <= 15; k++) begin
         step(); s0 = 1'b0; #2;
         if (r_err0) acc++;
      end
      chk("t4_no_early_err", 32'(acc), 32'd0);
      step(); tack = 1'b1; #2;
      chk("t4_ackwin_ack", 32'(r_ack0), 32'd1);
      chk("t4_ackwin_err", 32'(r_err0), 32'd0);
      step(); tack = 1'b0; #2;
      chk("t4_ackwin_tcyc", 32'(r_tcyc), 32'd1);

      // Timeout abort
      step(); s0 = 1'b1; #2;
      e_at = 0;
      for (int k = 1; k <= 16; k++) begin
         step(); s0 = 1'b0; #2;
         if (r_err0 && e_at == 0) e_at = k;
      end
      chk("t4_err_cycle", 32'(e_at), 32'd16);
      step(); #2;
      chk("t4_abort_tcyc", 32'(r_tcyc), 32'd0);
      chk("t4_abort_err", 32'(r_err0), 32'd0);
      chk("t4_abort_grant", 32'(r_grant), 32'd1);
      chk("t4_abort_stall", 32'(r_stall0), 32'd1);
      step(); #2;
      chk("t4_abort_hold", 32'(r_grant), 32'd1);
      chk("t4_abort_fx", 32'(f_tcyc), 32'd0);
      step(); c0 = 1'b0; #2;
      step(); #2;
      chk("t4_release", 32'(r_grant), 32'd0);

      // Simultaneous accept and ACK keep the count at 2
      step(); c0 = 1'b1; #2;
      step(); s0 = 1'b1; #2;
      step(); #2;
      for (int k = 0; k < 3; k++) begin
         step(); tack = 1'b1; #2;
         chk("t5_pipe_ack", 32'(r_ack0), 32'd1);
         chk("t5_pipe_stb", 32'(r_tstb), 32'd1);
      end
      step(); s0 = 1'b0; #2;
      chk("t5_drain1", 32'(r_ack0), 32'd1);
      step(); #2;
      chk("t5_drain2", 32'(r_ack0), 32'd1);
      step(); #2;
      chk("t5_spurious_own", 32'(r_ack0), 32'd0);
      step(); c0 = 1'b0; tack = 1'b0; #2;
      step(); tack = 1'b1; #2;
      chk("t5_idle_ack0", 32'(r_ack0), 32'd0);
      chk("t5_idle_ack1", 32'(r_ack1), 32'd0);
      chk("t5_idle_fx_ack0", 32'(f_ack0), 32'd0);

      // Reset during OWN1 with three outstanding
      step(); tack = 1'b0; c1 = 1'b1; #2;
      for (int k = 0; k < 3; k++) begin
         step(); s1 = 1'b1; #2;
      end
      step(); s1 = 1'b0; #2;
      chk("t6_pre_tcyc", 32'(r_tcyc), 32'd1);
      chk("t6_pre_grant", 32'(r_grant), 32'd2);
      #1 rst = 1'b0;
      #1;
      chk("t6_rst_tcyc", 32'(r_tcyc), 32'd0);
      chk("t6_rst_grant", 32'(r_grant), 32'd0);
      chk("t6_rst_stall0", 32'(r_stall0), 32'd1);
      chk("t6_rst_stall1", 32'(r_stall1), 32'd1);
      step(); rst = 1'b1; #2;
      chk("t6_post_idle", 32'(r_grant), 32'd0);
      step(); tack = 1'b1; #2;
      chk("t6_post_grant", 32'(r_grant), 32'd2);
      chk("t6_post_tcyc", 32'(r_tcyc), 32'd1);
      chk("t6_post_noack", 32'(r_ack1), 32'd0);
      step(); tack = 1'b0; c1 = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
